port_line_packer: RTL and testbench
===================================

// Module: port_line_packer
// PURPOSE
// - Stage directly downstream of the per-port write frontend: consumes its parsed word stream
//   (control word carrying dest/prior, then 16-bit payload words) and packs payload into
//   128-bit lines (8 words) for the shared packet SRAM writer.
// - Emits one descriptor per packet (dest, prior, length) to the queue manager.
// - Buffers lines in a small FIFO and drives full/almost_full back to the port interface.
// PARAMETERS
// - LINE_DEPTH  4   line FIFO depth in 128-bit entries, power of 2, >= 2
// - AF_LEVEL    2   almost_full asserts when free line entries <= AF_LEVEL
// - LEN_W       11  packet length counter width in words (max 2047)
// PORTS
// - clk          in   1    clock
// - rst          in   1    asynchronous reset, active-high
// - in_vld       in   1    input word valid (frontend "writting")
// - in_ctrl      in   1    current word is the control word; in_dest/in_prior valid with it
// - in_eop       in   1    current word is last payload word of packet
// - in_dest      in   4    destination port, sampled on ctrl word
// - in_prior     in   3    priority, sampled on ctrl word
// - in_data      in   16   payload word
// - line_vld     out  1    line available at FIFO head
// - line_rdy     in   1    SRAM writer accepts line (transfer when vld&rdy)
// - line_data    out  128  word k at bits [16k+15:16k], word 0 first received
// - line_words   out  4    valid words in line, 1..8
// - line_last    out  1    line holds the packet's final word
// - desc_vld     out  1    descriptor valid; held until desc_rdy
// - desc_rdy     in   1    queue manager accepts descriptor
// - desc_dest    out  4    descriptor destination
// - desc_prior   out  3    descriptor priority
// - desc_len     out  LEN_W payload word count (ctrl word excluded)
// - full         out  1    line FIFO has no free entry
// - almost_full  out  1    free entries <= AF_LEVEL
// - drop_err     out  1    sticky: word or descriptor lost; cleared only by rst
// BEHAVIOUR
// - Reset: all outputs 0; FSM IDLE; word index 0; FIFO empty; len 0.
// - FSM IDLE: in_vld&in_ctrl -> latch dest/prior, len=0, go PKT. Payload word in IDLE is
//   dropped, drop_err=1.
// - FSM PKT: each in_vld&!in_ctrl word written to assembly reg slot idx, idx++, len++
//   (saturate at all-ones, set drop_err). Line pushed to FIFO when idx wraps 7->0 or on
//   in_eop (line_words=idx+1, unused slots zero, line_last=1). On in_eop go DESC.
// - in_ctrl while in PKT: current partial line pushed with line_last=1, descriptor issued
//   for old packet, drop_err=1, new packet starts same cycle.
// - FSM DESC: desc_vld=1 the cycle after eop word; -> IDLE on desc_vld&desc_rdy. A new
//   ctrl word arriving in DESC is accepted (dest/prior latched into shadow regs) and FSM
//   goes PKT after handshake; a second packet end while desc pending sets drop_err and
//   overwrites nothing.
// - Latency: line visible at line_vld 1 cycle after its 8th/eop word; descriptor 1 cycle
//   after eop word. Descriptor never precedes its last line entering the FIFO.
// - FIFO push with FIFO full: line discarded, drop_err=1 (frontend must honour full).
//   Simultaneous push and pop when full: allowed, no loss.
// - full/almost_full registered from FIFO count after this cycle's push/pop.
// - Async rst mid-packet: assembly, FIFO, descriptor discarded; no partial line emitted.
// STRUCTURE
// - hydra_pkg: WORD_W=16, LINE_WORDS=8, LINE_W=128, typedef line_t {data,words,last},
//   typedef desc_t {dest,prior,len}, FSM state enum.
// - One sub-module: line_fifo (sync FIFO of line_t, depth LINE_DEPTH, count output).
// - Top: FSM, assembly register, index/len counters, descriptor register, flags.
// TESTING
// - 8-word pkt 0x0001..0x0008, ctrl dest=5 prior=3 -> 1 line words=8 last=1, data[15:0]=1,
//   desc {5,3,8}.
// - 11-word pkt -> line A words=8 last=0, line B words=3 last=1 slots 3..7 zero, len=11.
// - line_rdy=0, stream 5 full lines -> full after 4th push, almost_full after 2nd, 5th
//   line dropped, drop_err=1.
// - desc_rdy held 0 5 cycles, next ctrl arrives -> desc stable, new pkt starts after handshake.
// - rst pulse mid-packet (word 5) -> all outputs 0 next edge; following pkt packs from slot 0.
// - Back-to-back 1-word packets every 2 cycles, rdy=1 -> each line words=1, desc len=1, no drops.

Source files
------------

// File: rtl/port_line_packer_pkg.sv
// Shared types and constants for the port line packer.
// The packer consumes a frontend word stream (control word + 16-bit payload),
// packs payload into 128-bit lines and emits one descriptor per packet.
package port_line_packer_pkg;

  localparam int WORD_W     = 16;
  localparam int LINE_WORDS = 8;
  localparam int LINE_W     = WORD_W * LINE_WORDS;
  localparam int IDX_W      = $clog2(LINE_WORDS);
  localparam int LINE_CNT_W = 4;
  localparam int DEST_W     = 4;
  localparam int PRIOR_W    = 3;
  localparam int DEF_LEN_W  = 11;

  // One line as stored in the line FIFO.
  typedef struct packed {
    logic [LINE_W-1:0]     data;
    logic [LINE_CNT_W-1:0] words;
    logic                  last;
  } line_t;

  // Descriptor as seen by the queue manager (default length width).
  typedef struct packed {
    logic [DEST_W-1:0]    dest;
    logic [PRIOR_W-1:0]   prior;
    logic [DEF_LEN_W-1:0] len;
  } desc_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_DESC = 2'd2
  } state_e;

  // Slot index of the word just written -> number of valid words in the line.
  function automatic logic [LINE_CNT_W-1:0] words_in_line(input logic [IDX_W-1:0] idx);
    return LINE_CNT_W'(idx) + LINE_CNT_W'(1);
  endfunction

endpackage

// File: rtl/port_line_packer_line_fifo.sv
// Synchronous FIFO of packed lines.
// Ports: clk, rst (async, active-high); push/push_data write side; pop/head
// read side (head is the current oldest entry); empty, full, almost_full and
// count status. full/almost_full are registered from the post-update count.
// A push while full is accepted only when a pop happens in the same cycle.
module port_line_packer_line_fifo
  import port_line_packer_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  line_t                  push_data,
  input  logic                   pop,
  output line_t                  head,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  line_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          af_q, af_d;
  logic          push_ok, pop_ok;

  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    full_d   = (count_d == CW'(DEPTH));
    af_d     = ((CW'(DEPTH) - count_d) <= CW'(AF_LEVEL));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      af_q     <= af_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head        = mem_q[rd_ptr_q];
  assign empty       = (count_q == '0);
  assign full        = full_q;
  assign almost_full = af_q;
  assign count       = count_q;

endmodule

// File: rtl/port_line_packer.sv
// Port line packer: packs the frontend payload stream into 128-bit lines for
// the packet SRAM writer and issues one descriptor per packet.
// Ports: clk, rst (async, active-high); in_* frontend word stream;
// line_* line stream to the SRAM writer (vld/rdy); desc_* descriptor to the
// queue manager (vld/rdy); full/almost_full back-pressure; drop_err sticky.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | no packet open, no descriptor pending
// ST_PKT  | packet open, assembling payload words
// ST_DESC | descriptor pending; a new packet may already be open (pkt_open_q)
module port_line_packer
  import port_line_packer_pkg::*;
#(
  parameter int LINE_DEPTH = 4,
  parameter int AF_LEVEL   = 2,
  parameter int LEN_W      = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_vld,
  input  logic               in_ctrl,
  input  logic               in_eop,
  input  logic [3:0]         in_dest,
  input  logic [2:0]         in_prior,
  input  logic [15:0]        in_data,
  output logic               line_vld,
  input  logic               line_rdy,
  output logic [127:0]       line_data,
  output logic [3:0]         line_words,
  output logic               line_last,
  output logic               desc_vld,
  input  logic               desc_rdy,
  output logic [3:0]         desc_dest,
  output logic [2:0]         desc_prior,
  output logic [LEN_W-1:0]   desc_len,
  output logic               full,
  output logic               almost_full,
  output logic               drop_err
);

  localparam int               CNT_W   = $clog2(LINE_DEPTH) + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  state_e                          state_q, state_d;
  logic                            pkt_open_q, pkt_open_d;
  logic [DEST_W-1:0]               hdr_dest_q, hdr_dest_d;
  logic [PRIOR_W-1:0]              hdr_prior_q, hdr_prior_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [LEN_W-1:0]                len_q, len_d;
  logic [LINE_WORDS-1:0][WORD_W-1:0] asm_q, asm_d;
  logic                            desc_vld_q, desc_vld_d;
  logic [DEST_W-1:0]               desc_dest_q, desc_dest_d;
  logic [PRIOR_W-1:0]              desc_prior_q, desc_prior_d;
  logic [LEN_W-1:0]                desc_len_q, desc_len_d;
  logic                            drop_q, drop_d;

  logic             open_now, open_d;
  logic [LEN_W-1:0] len_inc, issue_len;
  logic             issue, push, pop, fifo_full_now;
  line_t            push_line, head_line;
  logic             fifo_empty, fifo_full, fifo_af;
  logic [CNT_W-1:0] fifo_count;

  assign pop           = ~fifo_empty & line_rdy;
  assign fifo_full_now = (fifo_count == CNT_W'(LINE_DEPTH));

  always_comb begin
    open_now     = (state_q == ST_PKT) || ((state_q == ST_DESC) && pkt_open_q);
    open_d       = open_now;
    hdr_dest_d   = hdr_dest_q;
    hdr_prior_d  = hdr_prior_q;
    idx_d        = idx_q;
    len_d        = len_q;
    asm_d        = asm_q;
    desc_vld_d   = desc_vld_q;
    desc_dest_d  = desc_dest_q;
    desc_prior_d = desc_prior_q;
    desc_len_d   = desc_len_q;
    drop_d       = drop_q;
    push         = 1'b0;
    push_line    = '0;
    issue        = 1'b0;
    issue_len    = len_q;
    len_inc      = (len_q == LEN_MAX) ? len_q : len_q + LEN_W'(1);

    if (desc_vld_q && desc_rdy) desc_vld_d = 1'b0;

    if (in_vld) begin
      if (in_ctrl) begin
        // A control word inside an open packet closes it early.
        if (open_now) begin
          drop_d    = 1'b1;
          issue     = 1'b1;
          issue_len = len_q;
          if (idx_q != '0) begin
            push            = 1'b1;
            push_line.data  = asm_q;
            push_line.words = LINE_CNT_W'(idx_q);
            push_line.last  = 1'b1;
          end
        end
        open_d      = 1'b1;
        hdr_dest_d  = in_dest;
        hdr_prior_d = in_prior;
        len_d       = '0;
        idx_d       = '0;
        asm_d       = '0;
      end else if (!open_now) begin
        drop_d = 1'b1;
      end else begin
        asm_d[idx_q] = in_data;
        if (len_q == LEN_MAX) drop_d = 1'b1;
        len_d = len_inc;
        idx_d = idx_q + IDX_W'(1);
        if ((idx_q == IDX_W'(LINE_WORDS - 1)) || in_eop) begin
          push            = 1'b1;
          push_line.data  = asm_d;
          push_line.words = words_in_line(idx_q);
          push_line.last  = in_eop;
          // Clearing here keeps unused slots of the next line zero.
          asm_d = '0;
          idx_d = '0;
        end
        if (in_eop) begin
          issue     = 1'b1;
          issue_len = len_inc;
          open_d    = 1'b0;
        end
      end
    end

    // The descriptor register is free if it is empty or handing off this cycle.
    if (issue) begin
      if (desc_vld_q && !desc_rdy) begin
        drop_d = 1'b1;
      end else begin
        desc_vld_d   = 1'b1;
        desc_dest_d  = hdr_dest_q;
        desc_prior_d = hdr_prior_q;
        desc_len_d   = issue_len;
      end
    end

    if (push && fifo_full_now && !pop) drop_d = 1'b1;

    pkt_open_d = open_d;
    state_d    = desc_vld_d ? ST_DESC : (open_d ? ST_PKT : ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pkt_open_q   <= 1'b0;
      hdr_dest_q   <= '0;
      hdr_prior_q  <= '0;
      idx_q        <= '0;
      len_q        <= '0;
      asm_q        <= '0;
      desc_vld_q   <= 1'b0;
      desc_dest_q  <= '0;
      desc_prior_q <= '0;
      desc_len_q   <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pkt_open_q   <= pkt_open_d;
      hdr_dest_q   <= hdr_dest_d;
      hdr_prior_q  <= hdr_prior_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      asm_q        <= asm_d;
      desc_vld_q   <= desc_vld_d;
      desc_dest_q  <= desc_dest_d;
      desc_prior_q <= desc_prior_d;
      desc_len_q   <= desc_len_d;
      drop_q       <= drop_d;
    end
  end

  port_line_packer_line_fifo #(
    .DEPTH   (LINE_DEPTH),
    .AF_LEVEL(AF_LEVEL)
  ) u_line_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (push_line),
    .pop        (pop),
    .head       (head_line),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .almost_full(fifo_af),
    .count      (fifo_count)
  );

  // FIFO storage is not reset, so the head is masked while empty.
  assign line_vld    = ~fifo_empty;
  assign line_data   = fifo_empty ? '0 : head_line.data;
  assign line_words  = fifo_empty ? '0 : head_line.words;
  assign line_last   = fifo_empty ? 1'b0 : head_line.last;
  assign desc_vld    = desc_vld_q;
  assign desc_dest   = desc_dest_q;
  assign desc_prior  = desc_prior_q;
  assign desc_len    = desc_len_q;
  assign full        = fifo_full;
  assign almost_full = fifo_af;
  assign drop_err    = drop_q;

endmodule

// File: tb/tb_port_line_packer.sv
// Bench for port_line_packer: directed scenarios plus random packets.
module tb_port_line_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_vld, in_ctrl, in_eop;
  logic [3:0]   in_dest;
  logic [2:0]   in_prior;
  logic [15:0]  in_data;
  logic         line_vld, line_rdy, line_last;
  logic [127:0] line_data;
  logic [3:0]   line_words;
  logic         desc_vld, desc_rdy;
  logic [3:0]   desc_dest;
  logic [2:0]   desc_prior;
  logic [10:0]  desc_len;
  logic         full, almost_full, drop_err;

  logic line_rdy_man, rnd_en, rnd_rdy;
  assign line_rdy = rnd_en ? rnd_rdy : line_rdy_man;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   words;
    logic         last;
  } exp_line_t;
  typedef struct {
    logic [3:0]  dest;
    logic [2:0]  prior;
    logic [10:0] len;
  } exp_desc_t;

  exp_line_t exp_lines[$];
  exp_desc_t exp_descs[$];

  port_line_packer #(.LINE_DEPTH(4), .AF_LEVEL(2), .LEN_W(11)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_ctrl(in_ctrl), .in_eop(in_eop),
    .in_dest(in_dest), .in_prior(in_prior), .in_data(in_data),
    .line_vld(line_vld), .line_rdy(line_rdy), .line_data(line_data),
    .line_words(line_words), .line_last(line_last),
    .desc_vld(desc_vld), .desc_rdy(desc_rdy), .desc_dest(desc_dest),
    .desc_prior(desc_prior), .desc_len(desc_len),
    .full(full), .almost_full(almost_full), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_rdy = 1'($urandom_range(0, 1));
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: split payload into 8-word lines, last line flagged, unused slots zero.
  function automatic void model_pkt(input logic [3:0] d, input logic [2:0] p,
                                    input logic [15:0] w[$], input int max_lines);
    exp_line_t e;
    exp_desc_t ed;
    int nl;
    nl = (w.size() + 7) / 8;
    for (int l = 0; l < nl; l++) begin
      e.data  = '0;
      e.words = 4'd0;
      for (int k = 0; k < 8; k++) begin
        if (l * 8 + k < w.size()) begin
          e.data[16*k +: 16] = w[l*8+k];
          e.words = e.words + 4'd1;
        end
      end
      e.last = (l == nl - 1);
      if (l < max_lines) exp_lines.push_back(e);
    end
    ed.dest  = d;
    ed.prior = p;
    ed.len   = 11'(w.size());
    exp_descs.push_back(ed);
  endfunction

  always @(negedge clk) begin
    exp_line_t el;
    exp_desc_t ed;
    if (!rst) begin
      if (line_vld && line_rdy) begin
        check("line_expected", 128'(exp_lines.size() > 0), 128'(1));
        if (exp_lines.size() > 0) begin
          el = exp_lines.pop_front();
          check("line_data", line_data, el.data);
          check("line_words", 128'(line_words), 128'(el.words));
          check("line_last", 128'(line_last), 128'(el.last));
        end
      end
      if (desc_vld && desc_rdy) begin
        check("desc_expected", 128'(exp_descs.size() > 0), 128'(1));
        if (exp_descs.size() > 0) begin
          ed = exp_descs.pop_front();
          check("desc_dest", 128'(desc_dest), 128'(ed.dest));
          check("desc_prior", 128'(desc_prior), 128'(ed.prior));
          check("desc_len", 128'(desc_len), 128'(ed.len));
        end
      end
    end
  end

  task automatic drive_word(input bit ctrl, input bit eop, input logic [3:0] d,
                            input logic [2:0] p, input logic [15:0] data, input bit honor);
    int g;
    g = 0;
    while (honor && full && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    if (honor && g >= 500) check("full_wait_timeout", 128'(full), 128'(0));
    in_vld = 1'b1; in_ctrl = ctrl; in_eop = eop;
    in_dest = d; in_prior = p; in_data = data;
    @(posedge clk); #1;
    in_vld = 1'b0; in_ctrl = 1'b0; in_eop = 1'b0; in_data = '0;
  endtask

  task automatic send_payload(input logic [15:0] w[$], input bit honor, input bit gaps);
    for (int i = 0; i < w.size(); i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        @(posedge clk); #1;
      end
      drive_word(1'b0, i == w.size() - 1, 4'd0, 3'd0, w[i], honor);
    end
  endtask

  task automatic send_pkt(input logic [3:0] d, input logic [2:0] p, input logic [15:0] w[$],
                          input bit honor, input bit gaps);
    drive_word(1'b1, 1'b0, d, p, 16'h0, honor);
    send_payload(w, honor, gaps);
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while ((exp_lines.size() != 0 || exp_descs.size() != 0) && g < 400) begin
      @(posedge clk); #1;
      g++;
    end
    check({tag, "_drain"}, 128'(exp_lines.size() + exp_descs.size()), 128'(0));
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_line_vld"}, 128'(line_vld), 128'(0));
    check({tag, "_line_data"}, line_data, 128'(0));
    check({tag, "_line_words"}, 128'(line_words), 128'(0));
    check({tag, "_line_last"}, 128'(line_last), 128'(0));
    check({tag, "_desc_vld"}, 128'(desc_vld), 128'(0));
    check({tag, "_desc_dest"}, 128'(desc_dest), 128'(0));
    check({tag, "_desc_prior"}, 128'(desc_prior), 128'(0));
    check({tag, "_desc_len"}, 128'(desc_len), 128'(0));
    check({tag, "_full"}, 128'(full), 128'(0));
    check({tag, "_almost_full"}, 128'(almost_full), 128'(0));
    check({tag, "_drop_err"}, 128'(drop_err), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] w[$];
    logic [15:0] wb[$];
    logic [3:0]  d;
    logic [2:0]  p;
    int          n, pushes;

    rst = 1'b1; in_vld = 1'b0; in_ctrl = 1'b0; in_eop = 1'b0;
    in_dest = '0; in_prior = '0; in_data = '0;
    line_rdy_man = 1'b1; desc_rdy = 1'b1; rnd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_hold");
    rst = 1'b0;
    @(posedge clk); #1;
    check_all_zero("after_reset");

    // 8-word packet, one full line.
    w = {};
    for (int i = 1; i <= 8; i++) w.push_back(16'(i));
    model_pkt(4'd5, 3'd3, w, 99);
    send_pkt(4'd5, 3'd3, w, 1'b1, 1'b0);
    check("pkt8_line_latency", 128'(line_vld), 128'(1));
    check("pkt8_word0", 128'(line_data[15:0]), 128'(16'h0001));
    check("pkt8_desc_latency", 128'(desc_vld), 128'(1));
    drain("pkt8");

    // 11-word packet, two lines.
    w = {};
    for (int i = 0; i < 11; i++) w.push_back(16'($urandom));
    d = 4'($urandom_range(0, 15)); p = 3'($urandom_range(0, 7));
    model_pkt(d, p, w, 99);
    send_pkt(d, p, w, 1'b1, 1'b0);
    drain("pkt11");
    check("pkt11_no_drop", 128'(drop_err), 128'(0));

    // Line FIFO overflow: 5 full lines with the writer stalled.
    line_rdy_man = 1'b0;
    w = {};
    for (int i = 0; i < 40; i++) w.push_back(16'($urandom));
    model_pkt(4'd2, 3'd1, w, 4);
    drive_word(1'b1, 1'b0, 4'd2, 3'd1, 16'h0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      drive_word(1'b0, i == 39, 4'd0, 3'd0, w[i], 1'b0);
      if ((i + 1) % 8 == 0) begin
        pushes = (i + 1) / 8;
        check($sformatf("ovf_af_%0d", pushes), 128'(almost_full), 128'(pushes >= 2));
        check($sformatf("ovf_full_%0d", pushes), 128'(full), 128'(pushes >= 4));
        check($sformatf("ovf_drop_%0d", pushes), 128'(drop_err), 128'(pushes >= 5));
      end
    end
    line_rdy_man = 1'b1;
    drain("ovf");
    check("ovf_drop_sticky", 128'(drop_err), 128'(1));
    check("ovf_full_cleared", 128'(full), 128'(0));

    // Descriptor held by queue manager while the next control word arrives.
    desc_rdy = 1'b0;
    w  = {16'h00a1, 16'h00a2, 16'h00a3};
    wb = {16'h0b01, 16'h0b02, 16'h0b03, 16'h0b04};
    model_pkt(4'd9, 3'd6, w, 99);
    send_pkt(4'd9, 3'd6, w, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        model_pkt(4'd7, 3'd2, wb, 99);
        drive_word(1'b1, 1'b0, 4'd7, 3'd2, 16'h0, 1'b1);
      end else begin
        @(posedge clk); #1;
      end
      check("hold_desc_vld", 128'(desc_vld), 128'(1));
      check("hold_desc_dest", 128'(desc_dest), 128'(9));
      check("hold_desc_prior", 128'(desc_prior), 128'(6));
      check("hold_desc_len", 128'(desc_len), 128'(3));
    end
    desc_rdy = 1'b1;
    @(posedge clk); #1;
    check("hold_desc_released", 128'(desc_vld), 128'(0));
    send_payload(wb, 1'b1, 1'b0);
    drain("hold");

    // Reset mid-packet, then a fresh packet packs from slot 0.
    w = {};
    for (int i = 0; i < 5; i++) w.push_back(16'($urandom));
    drive_word(1'b1, 1'b0, 4'd3, 3'd4, 16'h0, 1'b1);
    for (int i = 0; i < 5; i++) drive_word(1'b0, 1'b0, 4'd0, 3'd0, w[i], 1'b1);
    rst = 1'b1;
    #1;
    check_all_zero("rst_async");
    @(posedge clk); #1;
    check_all_zero("rst_edge");
    rst = 1'b0;
    @(posedge clk); #1;
    w = {16'h1111, 16'h2222, 16'h3333};
    model_pkt(4'd1, 3'd0, w, 99);
    send_pkt(4'd1, 3'd0, w, 1'b1, 1'b0);
    drain("post_rst");

    // Back-to-back single-word packets.
    for (int k = 0; k < 6; k++) begin
      w = {16'($urandom)};
      d = 4'(k + 8); p = 3'(k);
      model_pkt(d, p, w, 99);
      send_pkt(d, p, w, 1'b1, 1'b0);
    end
    drain("b2b");
    check("b2b_no_drop", 128'(drop_err), 128'(0));

    // Random packets with a randomly stalling line writer.
    rnd_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      n = $urandom_range(1, 20);
      w = {};
      for (int i = 0; i < n; i++) w.push_back(16'($urandom));
      d = 4'($urandom_range(0, 15)); p = 3'($urandom_range(0, 7));
      model_pkt(d, p, w, 99);
      send_pkt(d, p, w, 1'b1, 1'b1);
    end
    rnd_en = 1'b0;
    drain("rand");
    check("rand_no_drop", 128'(drop_err), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
